// File: rtl/sockit_spi_rpk.sv
// Input-queue repacker: de-interleaves de-serializer lane samples into serial
// bit order and packs them into QDW-bit words for the bus/DMA side, flushing
// partial words on the last-transfer marker and flagging dropped beats.
module sockit_spi_rpk #(
  parameter int unsigned SDW = 8,
  parameter int unsigned QDW = 4*SDW,
  parameter int unsigned SLW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           qui_vld,
  input  logic [3:0]     qui_ctl,
  input  logic [QDW-1:0] qui_dat,
  output logic           qui_rdy,
  output logic           bus_vld,
  output logic [QDW-1:0] bus_dat,
  output logic [SLW-1:0] bus_cnt,
  output logic           bus_lst,
  output logic           bus_new,
  input  logic           bus_rdy,
  output logic           sts_ovr,
  input  logic           sts_clr
);

  typedef enum logic [1:0] {
    IOM_3WIRE = 2'd0,
    IOM_STD   = 2'd1,
    IOM_DUAL  = 2'd2,
    IOM_QUAD  = 2'd3
  } iom_t;

  // accumulator and output register state
  logic [QDW-1:0] acc_q, acc_d;
  logic [SLW-1:0] acc_cnt_q, acc_cnt_d;
  logic           pend_new_q, pend_new_d;
  logic           bus_vld_q, bus_vld_d;
  logic [QDW-1:0] bus_dat_q, bus_dat_d;
  logic [SLW-1:0] bus_cnt_q, bus_cnt_d;
  logic           bus_lst_q, bus_lst_d;
  logic           bus_new_q, bus_new_d;
  logic           sts_ovr_q, sts_ovr_d;

  // decoded control and beat
  iom_t           iom;
  logic           ctl_new, ctl_lst;
  logic [SDW-1:0] lane [4];
  logic [QDW-1:0] beat;
  logic [SLW:0]   beat_w;
  logic [SLW:0]   cnt_sum;
  logic [QDW-1:0] merged;
  logic           ovf, ofree, flush, accept, overrun;

  assign iom     = iom_t'(qui_ctl[1:0]);
  assign ctl_lst = qui_ctl[2];
  assign ctl_new = qui_ctl[3];

  // split the input word into its four lanes
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      lane[i] = qui_dat[i*SDW +: SDW];
    end
  end

  // build the beat in serial (MSB-first) order and its width in slots
  always_comb begin
    beat   = '0;
    beat_w = (SLW+1)'(1);
    case (iom)
      IOM_3WIRE: begin
        beat[SDW-1:0] = lane[0];
        beat_w        = (SLW+1)'(1);
      end
      IOM_STD: begin
        beat[SDW-1:0] = lane[1];
        beat_w        = (SLW+1)'(1);
      end
      IOM_DUAL: begin
        for (int unsigned k = 0; k < SDW; k++) begin
          beat[2*k+1] = lane[1][k];
          beat[2*k]   = lane[0][k];
        end
        beat_w = (SLW+1)'(2);
      end
      IOM_QUAD: begin
        for (int unsigned k = 0; k < SDW; k++) begin
          beat[4*k+3] = lane[3][k];
          beat[4*k+2] = lane[2][k];
          beat[4*k+1] = lane[1][k];
          beat[4*k]   = lane[0][k];
        end
        beat_w = (SLW+1)'(4);
      end
      default: begin
        beat   = '0;
        beat_w = (SLW+1)'(1);
      end
    endcase
  end

  // handshake qualifiers
  always_comb begin
    cnt_sum = {1'b0, acc_cnt_q} + beat_w;
    ovf     = (cnt_sum > (SLW+1)'(4));
    ofree   = ~bus_vld_q | bus_rdy;
    qui_rdy = rst & ofree & ~ovf;
    flush   = qui_vld & ovf & ofree & (acc_cnt_q != '0);
    accept  = qui_vld & qui_rdy;
    // a beat stalled for a one-cycle flush is taken next cycle, not lost
    overrun = qui_vld & ~qui_rdy & ~flush;
  end

  // append the beat below the accumulated slots, zeroing slots beyond the count
  always_comb begin
    merged = (acc_q << (beat_w * SDW)) | beat;
    for (int unsigned s = 0; s < 4; s++) begin
      if (s >= 32'(cnt_sum)) begin
        merged[s*SDW +: SDW] = '0;
      end
    end
  end

  // next-state for accumulator, output register and overrun flag
  always_comb begin
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    pend_new_d = pend_new_q;
    bus_vld_d  = bus_vld_q & ~bus_rdy;
    bus_dat_d  = bus_dat_q;
    bus_cnt_d  = bus_cnt_q;
    bus_lst_d  = bus_lst_q;
    bus_new_d  = bus_new_q;

    if (flush) begin
      bus_vld_d  = 1'b1;
      bus_dat_d  = acc_q;
      bus_cnt_d  = acc_cnt_q;
      bus_lst_d  = 1'b0;
      bus_new_d  = pend_new_q;
      acc_d      = '0;
      acc_cnt_d  = '0;
      pend_new_d = 1'b0;
    end else if (accept) begin
      if ((cnt_sum == (SLW+1)'(4)) || ctl_lst) begin
        bus_vld_d  = 1'b1;
        bus_dat_d  = merged;
        bus_cnt_d  = cnt_sum[SLW-1:0];
        bus_lst_d  = ctl_lst;
        bus_new_d  = pend_new_q | ctl_new;
        acc_d      = '0;
        acc_cnt_d  = '0;
        pend_new_d = 1'b0;
      end else begin
        acc_d      = merged;
        acc_cnt_d  = cnt_sum[SLW-1:0];
        pend_new_d = pend_new_q | ctl_new;
      end
    end

    if (overrun) begin
      sts_ovr_d = 1'b1;
    end else if (sts_clr) begin
      sts_ovr_d = 1'b0;
    end else begin
      sts_ovr_d = sts_ovr_q;
    end
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      acc_cnt_q  <= '0;
      pend_new_q <= 1'b0;
      bus_vld_q  <= 1'b0;
      bus_dat_q  <= '0;
      bus_cnt_q  <= '0;
      bus_lst_q  <= 1'b0;
      bus_new_q  <= 1'b0;
      sts_ovr_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      pend_new_q <= pend_new_d;
      bus_vld_q  <= bus_vld_d;
      bus_dat_q  <= bus_dat_d;
      bus_cnt_q  <= bus_cnt_d;
      bus_lst_q  <= bus_lst_d;
      bus_new_q  <= bus_new_d;
      sts_ovr_q  <= sts_ovr_d;
    end
  end

  assign bus_vld = bus_vld_q;
  assign bus_dat = bus_dat_q;
  assign bus_cnt = bus_cnt_q;
  assign bus_lst = bus_lst_q;
  assign bus_new = bus_new_q;
  assign sts_ovr = sts_ovr_q;

endmodule

// File: tb/tb_sockit_spi_rpk.sv
// Scoreboard bench for sockit_spi_rpk: directed beats push expected words,
// a monitor pops and compares on every bus handshake.
module tb_sockit_spi_rpk;

  logic        clk;
  logic        rst;
  logic        qui_vld;
  logic [3:0]  qui_ctl;
  logic [31:0] qui_dat;
  logic        qui_rdy;
  logic        bus_vld;
  logic [31:0] bus_dat;
  logic [2:0]  bus_cnt;
  logic        bus_lst;
  logic        bus_new;
  logic        bus_rdy;
  logic        sts_ovr;
  logic        sts_clr;

  typedef struct packed {
    logic [31:0] dat;
    logic [2:0]  cnt;
    logic        lst;
    logic        nw;
  } word_t;

  word_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  sockit_spi_rpk #(.SDW(8), .QDW(32), .SLW(3)) dut (
    .clk(clk), .rst(rst),
    .qui_vld(qui_vld), .qui_ctl(qui_ctl), .qui_dat(qui_dat), .qui_rdy(qui_rdy),
    .bus_vld(bus_vld), .bus_dat(bus_dat), .bus_cnt(bus_cnt), .bus_lst(bus_lst),
    .bus_new(bus_new), .bus_rdy(bus_rdy), .sts_ovr(sts_ovr), .sts_clr(sts_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] c,
                             input logic l, input logic n);
    word_t w;
    w.dat = d; w.cnt = c; w.lst = l; w.nw = n;
    exp_q.push_back(w);
  endtask

  // monitor: compare every word the consumer takes
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (rst && bus_vld && bus_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", bus_dat, 32'hx);
        end else begin
          w = exp_q.pop_front();
          chk("word_dat", bus_dat, w.dat);
          chk("word_cnt", 32'(bus_cnt), 32'(w.cnt));
          chk("word_lst", 32'(bus_lst), 32'(w.lst));
          chk("word_new", 32'(bus_new), 32'(w.nw));
        end
      end
    end
  end

  // issue one beat and hold it until accepted; entered at posedge+1
  task automatic send(input logic [1:0] iom, input logic nw, input logic lst,
                      input logic [31:0] dat, output int waited);
    qui_vld = 1'b1;
    qui_ctl = {nw, lst, iom};
    qui_dat = dat;
    waited  = 0;
    @(negedge clk);
    while (!qui_rdy && waited < 8) begin
      waited++;
      @(negedge clk);
    end
    if (!qui_rdy) chk("beat_accept_timeout", 32'(qui_rdy), 32'd1);
    @(posedge clk); #1;
    qui_vld = 1'b0;
  endtask

  function automatic logic [31:0] std_beat(input logic [7:0] v);
    return {8'hEE, 8'hDD, v, 8'hBB};
  endfunction

  int w;

  initial begin
    rst = 1'b0; qui_vld = 1'b0; qui_ctl = '0; qui_dat = '0;
    bus_rdy = 1'b1; sts_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_vld", 32'(bus_vld), 32'd0);
    chk("rst_bus_dat", bus_dat, 32'd0);
    chk("rst_bus_cnt", 32'(bus_cnt), 32'd0);
    chk("rst_sts_ovr", 32'(sts_ovr), 32'd0);
    chk("rst_qui_rdy", 32'(qui_rdy), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // standard mode, four beats, new on first, lst on last
    expect_word(32'hA1B2C3D4, 3'd4, 1'b1, 1'b1);
    send(2'd1, 1'b1, 1'b0, std_beat(8'hA1), w);
    send(2'd1, 1'b0, 1'b0, std_beat(8'hB2), w);
    send(2'd1, 1'b0, 1'b0, std_beat(8'hC3), w);
    send(2'd1, 1'b0, 1'b1, std_beat(8'hD4), w);

    // dual mode
    expect_word(32'hAA55AA55, 3'd4, 1'b0, 1'b0);
    send(2'd2, 1'b0, 1'b0, {8'h00, 8'h00, 8'hF0, 8'h0F}, w);
    send(2'd2, 1'b0, 1'b0, {8'h00, 8'h00, 8'hF0, 8'h0F}, w);

    // quad mode with new
    expect_word(32'hAAAAAAAA, 3'd4, 1'b0, 1'b1);
    send(2'd3, 1'b1, 1'b0, {8'hFF, 8'h00, 8'hFF, 8'h00}, w);

    // short last
    expect_word(32'h00000012, 3'd1, 1'b1, 1'b0);
    send(2'd1, 1'b0, 1'b1, std_beat(8'h12), w);

    // overflow flush: one slot pending, then a quad beat
    expect_word(32'h00000034, 3'd1, 1'b0, 1'b0);
    expect_word(32'h88888888, 3'd4, 1'b1, 1'b0);
    send(2'd1, 1'b0, 1'b0, std_beat(8'h34), w);
    send(2'd3, 1'b0, 1'b1, {8'hFF, 8'h00, 8'h00, 8'h00}, w);
    chk("flush_stall_cycles", 32'(w), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // backpressure: output held full, extra beat is dropped
    bus_rdy = 1'b0;
    expect_word(32'h01020304, 3'd4, 1'b0, 1'b0);
    send(2'd1, 1'b0, 1'b0, std_beat(8'h01), w);
    send(2'd1, 1'b0, 1'b0, std_beat(8'h02), w);
    send(2'd1, 1'b0, 1'b0, std_beat(8'h03), w);
    send(2'd1, 1'b0, 1'b0, std_beat(8'h04), w);
    qui_vld = 1'b1; qui_ctl = 4'b0001; qui_dat = std_beat(8'h05);
    @(negedge clk);
    chk("bp_qui_rdy", 32'(qui_rdy), 32'd0);
    @(posedge clk); #1;
    qui_vld = 1'b0;
    @(negedge clk);
    chk("ovr_set", 32'(sts_ovr), 32'd1);
    chk("bp_dat_stable", bus_dat, 32'h01020304);
    @(posedge clk); #1;
    sts_clr = 1'b1;
    @(posedge clk); #1;
    sts_clr = 1'b0;
    chk("ovr_clr", 32'(sts_ovr), 32'd0);
    bus_rdy = 1'b1;
    @(posedge clk); #1;

    // reset in the middle of a word
    send(2'd1, 1'b0, 1'b0, std_beat(8'h66), w);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_bus_dat", bus_dat, 32'd0);
    chk("midrst_bus_cnt", 32'(bus_cnt), 32'd0);
    chk("midrst_bus_vld", 32'(bus_vld), 32'd0);
    chk("midrst_qui_rdy", 32'(qui_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    expect_word(32'h11223344, 3'd4, 1'b1, 1'b1);
    send(2'd1, 1'b1, 1'b0, std_beat(8'h11), w);
    send(2'd1, 1'b0, 1'b0, std_beat(8'h22), w);
    send(2'd1, 1'b0, 1'b0, std_beat(8'h33), w);
    send(2'd1, 1'b0, 1'b1, std_beat(8'h44), w);

    // drain
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("words_outstanding", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
